// File: rtl/baud_gen_frac.sv
// baud_gen_frac: programmable UART baud-rate generator.
//
// Produces a single-cycle oversampling tick (rx_tick) for the receiver and a
// bit-rate tick (tx_tick) for the transmitter. The divisor is loaded into
// shadow registers at any time. It moves to the active registers only on a
// period boundary, so a rate change never produces a shortened or stretched
// tick.
//
// Optional feature: define BAUD_FRAC_EN to enable the fractional divisor
// accumulator. Without it, div_frac is ignored and the period is exactly the
// integer divisor. The port list is identical in both builds.
//
// Ports:
//   clk       - clock
//   rst       - asynchronous, active-low reset
//   en        - generator enable; when low, the counters are held at 0 and
//               shadow registers flow straight to the active registers
//   div_int   - integer clocks per rx_tick (values below 2 are clamped to 2)
//   div_frac  - fractional clocks per rx_tick, in units of 1/2^FRAC_W
//   div_load  - single-cycle strobe capturing div_int/div_frac into the shadows
//   rx_tick   - registered 1-cycle pulse at baud*OVERSAMPLE
//   tx_tick   - registered 1-cycle pulse at the baud rate
//   os_phase  - count of rx_tick events modulo OVERSAMPLE
module baud_gen_frac #(
    parameter int unsigned FREQUENCY    = 100000000,
    parameter int unsigned DEFAULT_BAUD = 9600,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned FRAC_W       = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [DIV_W-1:0]              div_int,
    input  logic [FRAC_W-1:0]             div_frac,
    input  logic                          div_load,
    output logic                          rx_tick,
    output logic                          tx_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

    localparam int unsigned PH_W        = $clog2(OVERSAMPLE);
    localparam int unsigned DEF_RAW     = FREQUENCY / (DEFAULT_BAUD * OVERSAMPLE);
    localparam int unsigned DEF_CLAMPED = (DEF_RAW < 2) ? 2 : DEF_RAW;

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEF_CLAMPED);
    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);
    localparam logic [DIV_W:0]   CNT_ONE = (DIV_W + 1)'(1);
    localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(OVERSAMPLE - 1);

    logic [DIV_W-1:0] sh_int;
    logic [DIV_W-1:0] act_int;
    logic [DIV_W-1:0] div_clamped;
    logic [DIV_W:0]   cnt;
    logic [DIV_W:0]   period;
    logic [DIV_W:0]   last_cnt;
    logic             carry;
    logic             boundary;
    logic             phase_wrap;

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] sh_frac;
    logic [FRAC_W-1:0] act_frac;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   frac_sum;

    // acc and act_frac only change on a boundary (or while disabled), so the
    // carry seen during a period is the one evaluated as that period started.
    assign frac_sum = {1'b0, acc} + {1'b0, act_frac};
    assign carry    = frac_sum[FRAC_W];
`else
    logic unused_frac;

    assign unused_frac = ^div_frac;
    assign carry       = 1'b0;
`endif

    always_comb begin
        div_clamped = (div_int < MIN_DIV) ? MIN_DIV : div_int;
        period      = {1'b0, act_int} + {{DIV_W{1'b0}}, carry};
        last_cnt    = period - CNT_ONE;
        boundary    = (cnt == last_cnt);
        phase_wrap  = (os_phase == PH_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_int   <= DEF_DIV;
            act_int  <= DEF_DIV;
            cnt      <= '0;
            os_phase <= '0;
            rx_tick  <= 1'b0;
            tx_tick  <= 1'b0;
`ifdef BAUD_FRAC_EN
            sh_frac  <= '0;
            act_frac <= '0;
            acc      <= '0;
`endif
        end else begin
            if (div_load) begin
                sh_int  <= div_clamped;
`ifdef BAUD_FRAC_EN
                sh_frac <= div_frac;
`endif
            end

            if (!en) begin
                // Abort any period in progress; the divisor tracks the shadow.
                cnt      <= '0;
                os_phase <= '0;
                rx_tick  <= 1'b0;
                tx_tick  <= 1'b0;
                act_int  <= sh_int;
`ifdef BAUD_FRAC_EN
                acc      <= '0;
                act_frac <= sh_frac;
`endif
            end else if (boundary) begin
                // Shadow is read before this cycle's load lands, so a load in
                // the boundary cycle takes effect at the following boundary.
                cnt      <= '0;
                rx_tick  <= 1'b1;
                tx_tick  <= phase_wrap;
                os_phase <= phase_wrap ? '0 : os_phase + PH_ONE;
                act_int  <= sh_int;
`ifdef BAUD_FRAC_EN
                acc      <= frac_sum[FRAC_W-1:0];
                act_frac <= sh_frac;
`endif
            end else begin
                cnt     <= cnt + CNT_ONE;
                rx_tick <= 1'b0;
                tx_tick <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb_baud_gen_frac: directed, scoreboarded bench for baud_gen_frac.
// Expected tick spacing, tx_tick and os_phase are queued as stimulus is
// applied and compared as each rx_tick arrives.
module tb_baud_gen_frac;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_load;
    logic        rx_tick;
    logic        tx_tick;
    logic [3:0]  os_phase;

    baud_gen_frac #(
        .FREQUENCY   (1600),
        .DEFAULT_BAUD(10),
        .OVERSAMPLE  (16),
        .DIV_W       (16),
        .FRAC_W      (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div_int (div_int),
        .div_frac(div_frac),
        .div_load(div_load),
        .rx_tick (rx_tick),
        .tx_tick (tx_tick),
        .os_phase(os_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int gap;
        bit tx;
        int ph;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;
    int   last    = 0;
    int   ph_m    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Queue one expected rx_tick: spacing from the previous tick plus the
    // oversample phase and tx_tick the model predicts for it.
    function automatic void push_tick(input int gap);
        ph_m = (ph_m + 1) % 16;
        sb_q.push_back('{gap: gap, tx: (ph_m == 0), ph: ph_m});
    endfunction

    task automatic load_div(input int i, input int f);
        div_int  = 16'(i);
        div_frac = 4'(f);
        div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
    endtask

    task automatic wait_rx(input int budget, output bit seen);
        int i;
        seen = 1'b0;
        i    = 0;
        while (!seen && i < budget) begin
            @(negedge clk);
            if (tx_tick && !rx_tick) check("tx_without_rx", {31'b0, tx_tick}, 32'd0);
            if (rx_tick) seen = 1'b1;
            i++;
        end
    endtask

    task automatic run_all(input string tag);
        exp_t e;
        bit   seen;
        int   k;
        k = 0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            wait_rx(64, seen);
            if (!seen) begin
                check($sformatf("%s_timeout%0d", tag, k), {31'b0, rx_tick}, 32'd1);
                sb_q.delete();
            end else begin
                check($sformatf("%s_gap%0d", tag, k), cyc - last, e.gap);
                last = cyc;
                check($sformatf("%s_tx%0d", tag, k), {31'b0, tx_tick}, {31'b0, e.tx});
                check($sformatf("%s_ph%0d", tag, k), {28'b0, os_phase}, e.ph);
            end
            k++;
        end
    endtask

    initial begin
        int start;
        int span;

        rst      = 1'b0;
        en       = 1'b0;
        div_int  = '0;
        div_frac = '0;
        div_load = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_rx", {31'b0, rx_tick}, 32'd0);
        check("rst_tx", {31'b0, tx_tick}, 32'd0);
        check("rst_ph", {28'b0, os_phase}, 32'd0);

        // Default divisor: 1600/(10*16) = 10 cycles per rx_tick.
        @(negedge clk);
        rst  = 1'b1;
        en   = 1'b1;
        last = cyc;
        ph_m = 0;
        for (int i = 0; i < 32; i++) push_tick(10);
        run_all("dflt");

        // Fractional divisor 4 + 8/16, loaded while disabled.
        en = 1'b0;
        @(negedge clk);
        check("dis_ph", {28'b0, os_phase}, 32'd0);
        check("dis_rx", {31'b0, rx_tick}, 32'd0);
        load_div(4, 8);
        @(negedge clk);
        en    = 1'b1;
        last  = cyc;
        start = cyc;
        ph_m  = 0;
`ifdef BAUD_FRAC_EN
        for (int i = 0; i < 16; i++) push_tick((i % 2 == 0) ? 4 : 5);
        span = 72;
`else
        for (int i = 0; i < 16; i++) push_tick(4);
        span = 64;
`endif
        run_all("frac");
        check("frac_span", last - start, span);

        // Back to a 10-cycle period, then load 20 while cnt is 3.
        en = 1'b0;
        @(negedge clk);
        load_div(10, 0);
        @(negedge clk);
        en   = 1'b1;
        last = cyc;
        ph_m = 0;
        push_tick(10);
        push_tick(10);
        run_all("p10");
        repeat (3) @(negedge clk);
        load_div(20, 0);
        push_tick(10);
        push_tick(20);
        push_tick(20);
        run_all("midload");

        // Clamp: 0 then 1 both become 2 at the next boundary.
        load_div(0, 0);
        load_div(1, 0);
        push_tick(20);
        for (int i = 0; i < 7; i++) push_tick(2);
        run_all("clamp");

        // Restore 10, then drop en at cnt=5 for three cycles.
        load_div(10, 0);
        push_tick(2);
        push_tick(10);
        push_tick(10);
        run_all("restore");
        repeat (5) @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("off_rx%0d", i), {31'b0, rx_tick}, 32'd0);
            check($sformatf("off_ph%0d", i), {28'b0, os_phase}, 32'd0);
        end
        en   = 1'b1;
        last = cyc;
        ph_m = 0;
        push_tick(10);
        push_tick(10);
        run_all("reen");

        // Switch to 6, then reset in a cycle where rx_tick is high.
        load_div(6, 0);
        push_tick(10);
        push_tick(6);
        push_tick(6);
        run_all("div6");
        #1 rst = 1'b0;
        #1;
        check("arst_rx", {31'b0, rx_tick}, 32'd0);
        check("arst_tx", {31'b0, tx_tick}, 32'd0);
        check("arst_ph", {28'b0, os_phase}, 32'd0);
        @(negedge clk);
        rst  = 1'b1;
        last = cyc;
        ph_m = 0;
        push_tick(10);
        push_tick(10);
        run_all("postrst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
